// File: rtl/exc_commit_pkg.sv
// exc_commit_pkg: shared event bit indices, exception vector default and commit FSM encoding
package exc_commit_pkg;

    // Bit positions inside the one-hot exc_type vector {int, rine, rdae, ades, sys, bp, ri, ov}
    localparam int EXC_INT  = 7;
    localparam int EXC_RINE = 6;
    localparam int EXC_RDAE = 5;
    localparam int EXC_ADES = 4;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BP   = 2;
    localparam int EXC_RI   = 1;
    localparam int EXC_OV   = 0;

    // General exception vector with BEV tied to 1
    localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hbfc00380;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/exc_commit_prio_enc.sv
// exc_prio_enc: raw exception/interrupt vector to single winning one-hot bit
module exc_prio_enc
    import exc_commit_pkg::*;
(
    input  logic [7:0] raw_i,
    output logic [7:0] onehot_o
);

    // Fixed priority: int > rine > ri > sys > bp > ov > rdae > ades
    always_comb begin
        onehot_o = '0;
        if (raw_i[EXC_INT])       onehot_o[EXC_INT]  = 1'b1;
        else if (raw_i[EXC_RINE]) onehot_o[EXC_RINE] = 1'b1;
        else if (raw_i[EXC_RI])   onehot_o[EXC_RI]   = 1'b1;
        else if (raw_i[EXC_SYS])  onehot_o[EXC_SYS]  = 1'b1;
        else if (raw_i[EXC_BP])   onehot_o[EXC_BP]   = 1'b1;
        else if (raw_i[EXC_OV])   onehot_o[EXC_OV]   = 1'b1;
        else if (raw_i[EXC_RDAE]) onehot_o[EXC_RDAE] = 1'b1;
        else if (raw_i[EXC_ADES]) onehot_o[EXC_ADES] = 1'b1;
    end

endmodule

// File: rtl/exc_commit.sv
// exc_commit: write-back commit of exceptions, interrupts and ERET with flush and fetch redirect
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_is_slot,
    input  logic [6:0]  in_exc,
    input  logic [31:0] in_badvaddr,
    input  logic        in_eret,
    input  logic        int_happen,
    input  logic [31:0] epc,
    output logic [7:0]  exc_type,
    output logic [31:0] exc_pc,
    output logic        exc_is_slot,
    output logic [31:0] exc_badvaddr,
    output logic        eret_out,
    output logic        retire_valid,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    state_e      state_q, state_d;
    logic [7:0]  ev;
    logic        accept, has_ev, redirect;
    logic [7:0]  exc_type_q, exc_type_d;
    logic        eret_q, eret_d, retire_q, retire_d;
    logic [31:0] exc_pc_q, exc_pc_d, exc_badvaddr_q, exc_badvaddr_d;
    logic        exc_is_slot_q, exc_is_slot_d;
    logic        flush_q, flush_d, redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    // Only RUN commits; anything accepted in HOLD is dropped, interrupt included
    assign accept   = (state_q == ST_RUN) && in_valid;
    assign has_ev   = |ev;
    assign redirect = accept && (has_ev || in_eret);

    exc_prio_enc u_prio (
        .raw_i    ({int_happen, in_exc}),
        .onehot_o (ev)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next state: enter HOLD on event/eret, leave once fetch takes the redirect
    always_comb begin
        state_d = (state_q == ST_RUN) ? (redirect ? ST_HOLD : ST_RUN)
                                      : ((redirect_valid_q && redirect_ready) ? ST_RUN : ST_HOLD);
    end

    // State-decoded outputs: commit never back-pressures (HOLD swallows input)
    always_comb begin
        in_ready = 1'b1;
    end

    // Next values of the registered commit/redirect outputs
    always_comb begin
        exc_type_d       = accept ? ev : 8'h00;
        eret_d           = accept && in_eret && !has_ev;
        retire_d         = accept && !has_ev && !in_eret;
        exc_pc_d         = (accept && has_ev) ? in_pc : exc_pc_q;
        exc_is_slot_d    = (accept && has_ev) ? in_is_slot : exc_is_slot_q;
        exc_badvaddr_d   = (accept && has_ev) ? in_badvaddr : exc_badvaddr_q;
        redirect_pc_d    = redirect ? (has_ev ? EXC_ENTRY : epc) : redirect_pc_q;
        flush_d          = (state_d == ST_HOLD);
        redirect_valid_d = (state_d == ST_HOLD);
    end

    // Output registers; async reset drops pulses and redirect at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_type_q       <= '0;
            eret_q           <= 1'b0;
            retire_q         <= 1'b0;
            exc_pc_q         <= '0;
            exc_is_slot_q    <= 1'b0;
            exc_badvaddr_q   <= '0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            exc_type_q       <= exc_type_d;
            eret_q           <= eret_d;
            retire_q         <= retire_d;
            exc_pc_q         <= exc_pc_d;
            exc_is_slot_q    <= exc_is_slot_d;
            exc_badvaddr_q   <= exc_badvaddr_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

    assign exc_type       = exc_type_q;
    assign eret_out       = eret_q;
    assign retire_valid   = retire_q;
    assign exc_pc         = exc_pc_q;
    assign exc_is_slot    = exc_is_slot_q;
    assign exc_badvaddr   = exc_badvaddr_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;

endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit: scoreboard bench for the exception commit unit
module tb_exc_commit;

    localparam logic [31:0] ENTRY = 32'hbfc00380;
    localparam logic [31:0] EPC   = 32'h80001234;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_is_slot = 1'b0, in_eret = 1'b0, int_happen = 1'b0;
    logic        redirect_ready = 1'b0;
    logic [31:0] in_pc = '0, in_badvaddr = '0, epc = EPC;
    logic [6:0]  in_exc = '0;
    logic        in_ready, exc_is_slot, eret_out, retire_valid, flush, redirect_valid;
    logic [7:0]  exc_type;
    logic [31:0] exc_pc, exc_badvaddr, redirect_pc;

    typedef struct {
        logic [7:0]  typ;
        logic        er;
        logic        rt;
        logic [31:0] pc;
        logic        sl;
        logic [31:0] bad;
        logic [31:0] rpc;
        logic        fl;
        int          stamp;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exc_commit dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_is_slot     (in_is_slot),
        .in_exc         (in_exc),
        .in_badvaddr    (in_badvaddr),
        .in_eret        (in_eret),
        .int_happen     (int_happen),
        .epc            (epc),
        .exc_type       (exc_type),
        .exc_pc         (exc_pc),
        .exc_is_slot    (exc_is_slot),
        .exc_badvaddr   (exc_badvaddr),
        .eret_out       (eret_out),
        .retire_valid   (retire_valid),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // One input cycle: applied just after a rising edge, sampled at the next one
    task automatic cyc_in(input logic v, input logic [31:0] pc, input logic sl, input logic [6:0] ex,
                          input logic [31:0] bad, input logic er, input logic it, input logic rr);
        @(posedge clk);
        #1;
        in_valid = v; in_pc = pc; in_is_slot = sl; in_exc = ex;
        in_badvaddr = bad; in_eret = er; int_happen = it; redirect_ready = rr;
    endtask

    // Expected pulse one cycle after the currently applied instruction
    task automatic exp_ev(input logic [7:0] t, input logic e, input logic r, input logic [31:0] rp);
        exp_t x;
        x.typ = t; x.er = e; x.rt = r; x.pc = in_pc; x.sl = in_is_slot;
        x.bad = in_badvaddr; x.rpc = rp; x.fl = (t != 8'h00) || e; x.stamp = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic chk_hold(input string nm, input logic [31:0] rp);
        chk({nm, "_flush"}, 32'(flush), 32'd1);
        chk({nm, "_rvalid"}, 32'(redirect_valid), 32'd1);
        chk({nm, "_rpc"}, redirect_pc, rp);
        chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Monitor: every commit pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (exc_type != 8'h00 || eret_out || retire_valid)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {22'd0, exc_type, eret_out, retire_valid}, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("ev_cycle", 32'(cyc), 32'(me.stamp));
                chk("exc_type", 32'(exc_type), 32'(me.typ));
                chk("eret_out", 32'(eret_out), 32'(me.er));
                chk("retire_valid", 32'(retire_valid), 32'(me.rt));
                chk("flush", 32'(flush), 32'(me.fl));
                chk("redirect_valid", 32'(redirect_valid), 32'(me.fl));
                if (me.typ != 8'h00) begin
                    chk("exc_pc", exc_pc, me.pc);
                    chk("exc_is_slot", 32'(exc_is_slot), 32'(me.sl));
                    chk("exc_badvaddr", exc_badvaddr, me.bad);
                end
                if (me.fl) chk("redirect_pc", redirect_pc, me.rpc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_exc_type", 32'(exc_type), 32'd0);
        chk("rst_eret", 32'(eret_out), 32'd0);
        chk("rst_retire", 32'(retire_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_rvalid", 32'(redirect_valid), 32'd0);
        chk("rst_exc_pc", exc_pc, 32'd0);
        chk("rst_badvaddr", exc_badvaddr, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Overflow exception; redirect_ready already high still gives one HOLD cycle
        cyc_in(1, 32'hbfc00100, 0, 7'h01, 32'h0000_1234, 0, 0, 1);
        exp_ev(8'h01, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);
        chk_hold("exc_hold", ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("exc_back_run_flush", 32'(flush), 32'd0);
        chk("exc_back_run_rvalid", 32'(redirect_valid), 32'd0);

        // Priority: int beats rdae+ri; without int, ri beats rdae
        cyc_in(1, 32'h0000_0100, 1, 7'h22, 32'hdead_0000, 0, 1, 1);
        exp_ev(8'h80, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);
        cyc_in(1, 32'h0000_0104, 0, 7'h22, 32'hdead_0004, 0, 0, 1);
        exp_ev(8'h02, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);
        cyc_in(1, 32'h0000_0108, 0, 7'h70, 32'hdead_0008, 0, 0, 1);
        exp_ev(8'h40, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);
        cyc_in(1, 32'h0000_010c, 1, 7'h10, 32'hdead_000c, 0, 0, 1);
        exp_ev(8'h10, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);

        // ERET with fetch stalling 3 cycles; instructions during HOLD are discarded
        cyc_in(1, 32'h0000_0200, 0, 7'h00, 0, 1, 0, 0);
        exp_ev(8'h00, 1, 0, EPC);
        for (int i = 0; i < 3; i++) begin
            cyc_in(1, 32'h0000_0204 + 32'(4 * i), 0, 7'h01, 0, 0, 1, 0);
            chk_hold("eret_hold", EPC);
        end
        cyc_in(1, 32'h0000_0210, 0, 7'h00, 0, 0, 0, 1);
        chk_hold("eret_hold_last", EPC);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("eret_done_rvalid", 32'(redirect_valid), 32'd0);
        chk("eret_done_flush", 32'(flush), 32'd0);

        // ERET together with interrupt: interrupt wins, no eret pulse
        cyc_in(1, 32'h0000_0300, 0, 7'h00, 0, 1, 1, 1);
        exp_ev(8'h80, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);

        // Back-to-back plain instructions retire every cycle
        for (int i = 0; i < 4; i++) begin
            cyc_in(1, 32'h0000_0400 + 32'(4 * i), 0, 7'h00, 0, 0, 0, 0);
            exp_ev(8'h00, 0, 1, 0);
        end

        // Interrupt pending with no instruction attaches to the next one
        for (int i = 0; i < 5; i++) cyc_in(0, 0, 0, 0, 0, 0, 1, 0);
        cyc_in(1, 32'h0000_0500, 1, 7'h00, 32'h0000_0abc, 0, 1, 1);
        exp_ev(8'h80, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of HOLD drops redirect and flush asynchronously
        cyc_in(1, 32'h0000_0600, 0, 7'h04, 0, 0, 0, 0);
        exp_ev(8'h04, 0, 0, ENTRY);
        cyc_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk_hold("pre_rst_hold", ENTRY);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rvalid", 32'(redirect_valid), 32'd0);
        chk("async_rst_flush", 32'(flush), 32'd0);
        chk("async_rst_type", 32'(exc_type), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        cyc_in(1, 32'h0000_0700, 0, 7'h00, 0, 0, 0, 0);
        exp_ev(8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_run_flush", 32'(flush), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
